// File: rtl/timer_dev_pkg.sv
// Shared timer definitions: register offsets, CTRL layout, MODE codes and FSM encoding.
// The CPU-side bus bridge imports the same package so both sides agree on the map.
package timer_dev_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tmr_state_e;

endpackage

// File: rtl/timer_dev.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a maskable irq.
// A CTRL write in flight is seen by the FSM on the same edge it is stored.
module timer_dev
    import timer_dev_pkg::*;
#(
    parameter logic [31:0] CTRL_MASK = 32'h0000_000F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);

    logic [31:0] ctrl_q, ctrl_d, ctrl_eff;
    logic [31:0] preset_q;
    logic [31:0] count_q, count_d;
    tmr_state_e  state_q, state_d;
    logic        ctrl_wr, preset_wr, en_eff, auto_eff;

    assign ctrl_wr   = we && (addr == ADDR_CTRL);
    assign preset_wr = we && (addr == ADDR_PRESET);
    assign ctrl_eff  = ctrl_wr ? (wd & CTRL_MASK) : ctrl_q;
    assign en_eff    = ctrl_eff[CTRL_EN];
    assign auto_eff  = (ctrl_eff[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ctrl_d  = ctrl_eff;
        case (state_q)
            ST_IDLE: if (en_eff) state_d = ST_LOAD;
            ST_LOAD: begin
                count_d = preset_q;
                state_d = (preset_q == 32'd0) ? ST_INT : ST_CNT;
            end
            ST_CNT: begin
                if (!en_eff) begin
                    state_d = ST_IDLE;
                end else if (count_q <= 32'd1) begin
                    count_d = 32'd0;
                    state_d = ST_INT;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            ST_INT: begin
                if (auto_eff)     state_d = en_eff ? ST_LOAD : ST_IDLE;
                else if (ctrl_wr) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // One-shot drops EN when it fires, unless software rewrote CTRL on that edge.
        if (state_d == ST_INT && !auto_eff && !ctrl_wr)
            ctrl_d[CTRL_EN] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_q   <= 32'd0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            state_q  <= ST_IDLE;
        end else begin
            ctrl_q  <= ctrl_d;
            count_q <= count_d;
            state_q <= state_d;
            if (preset_wr) preset_q <= wd;
        end
    end

    always_comb begin
        rd = 32'd0;
        case (addr)
            ADDR_CTRL:   rd = ctrl_q;
            ADDR_PRESET: rd = preset_q;
            ADDR_COUNT:  rd = count_q;
            ADDR_RSVD:   rd = 32'd0;
            default:     rd = 32'd0;
        endcase
    end

    assign irq = (state_q == ST_INT) && ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: a per-cycle vector table plus hand-written corner sequences.
module tb_timer_dev;
    import timer_dev_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wd = 32'd0;
    logic [31:0] rd;
    logic        irq;

    int n_run = 0;
    int n_fail = 0;

    timer_dev dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .addr (addr),
        .wd   (wd),
        .rd   (rd),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vt[17];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d);
        rst = r; we = w; addr = a; wd = d;
        @(negedge clk);
    endtask

    task automatic rdchk(input string name, input logic [1:0] a, input logic [31:0] exp);
        we = 1'b0; addr = a;
        #1;
        chk32(name, rd, exp);
    endtask

    initial begin
        logic [31:0] ar_cnt[10];
        logic        ar_irq[10];

        // rst, we, addr, wd, expected rd (same addr, after the edge), expected irq
        vt[0]  = '{1'b0, 1'b1, ADDR_CTRL,   32'hFFFF_FFFF, 32'h0, 1'b0};
        vt[1]  = '{1'b0, 1'b0, ADDR_PRESET, 32'h0,         32'h0, 1'b0};
        vt[2]  = '{1'b0, 1'b0, ADDR_COUNT,  32'h0,         32'h0, 1'b0};
        vt[3]  = '{1'b1, 1'b1, ADDR_CTRL,   32'hFFFF_FFF6, 32'h6, 1'b0};
        vt[4]  = '{1'b1, 1'b1, ADDR_RSVD,   32'hFFFF_FFFF, 32'h0, 1'b0};
        vt[5]  = '{1'b1, 1'b1, ADDR_CTRL,   32'h0,         32'h0, 1'b0};
        vt[6]  = '{1'b1, 1'b1, ADDR_PRESET, 32'd5,         32'd5, 1'b0};
        vt[7]  = '{1'b1, 1'b1, ADDR_CTRL,   32'h9,         32'h9, 1'b0};
        vt[8]  = '{1'b1, 1'b0, ADDR_COUNT,  32'h0,         32'd5, 1'b0};
        vt[9]  = '{1'b1, 1'b0, ADDR_COUNT,  32'h0,         32'd4, 1'b0};
        vt[10] = '{1'b1, 1'b0, ADDR_COUNT,  32'h0,         32'd3, 1'b0};
        vt[11] = '{1'b1, 1'b0, ADDR_COUNT,  32'h0,         32'd2, 1'b0};
        vt[12] = '{1'b1, 1'b0, ADDR_COUNT,  32'h0,         32'd1, 1'b0};
        vt[13] = '{1'b1, 1'b0, ADDR_COUNT,  32'h0,         32'd0, 1'b1};
        vt[14] = '{1'b1, 1'b0, ADDR_CTRL,   32'h0,         32'h8, 1'b1};
        vt[15] = '{1'b1, 1'b1, ADDR_CTRL,   32'h8,         32'h8, 1'b0};
        vt[16] = '{1'b1, 1'b0, ADDR_COUNT,  32'h0,         32'd0, 1'b0};

        ar_cnt = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
        ar_irq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            cyc(vt[i].rst, vt[i].we, vt[i].addr, vt[i].wd);
            chk32($sformatf("vec%0d_rd", i), rd, vt[i].exp_rd);
            chk32($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vt[i].exp_irq});
        end

        // Auto-reload: LOAD, 3 x CNT, INT repeating with a one-cycle irq.
        cyc(1'b0, 1'b0, ADDR_CTRL, 32'h0);
        cyc(1'b1, 1'b1, ADDR_PRESET, 32'd3);
        cyc(1'b1, 1'b1, ADDR_CTRL, 32'hB);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, ADDR_COUNT, 32'h0);
            chk32($sformatf("ar%0d_cnt", i), rd, ar_cnt[i]);
            chk32($sformatf("ar%0d_irq", i), {31'd0, irq}, {31'd0, ar_irq[i]});
        end

        // Stop mid-count at COUNT=6.
        cyc(1'b0, 1'b0, ADDR_CTRL, 32'h0);
        cyc(1'b1, 1'b1, ADDR_PRESET, 32'd10);
        cyc(1'b1, 1'b1, ADDR_CTRL, 32'h1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, ADDR_COUNT, 32'h0);
        rdchk("stop_pre_cnt", ADDR_COUNT, 32'd6);
        cyc(1'b1, 1'b1, ADDR_CTRL, 32'h0);
        rdchk("stop_frozen_cnt", ADDR_COUNT, 32'd6);
        cyc(1'b1, 1'b1, ADDR_CTRL, 32'h8);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, ADDR_COUNT, 32'h0);
            chk32($sformatf("stop_irq%0d", i), {31'd0, irq}, 32'd0);
        end
        rdchk("stop_hold_cnt", ADDR_COUNT, 32'd6);

        // PRESET=0: irq two edges after the CTRL write.
        cyc(1'b0, 1'b0, ADDR_CTRL, 32'h0);
        cyc(1'b1, 1'b1, ADDR_CTRL, 32'h9);
        chk32("p0_irq_e0", {31'd0, irq}, 32'd0);
        cyc(1'b1, 1'b0, ADDR_COUNT, 32'h0);
        chk32("p0_irq_e1", {31'd0, irq}, 32'd1);
        chk32("p0_cnt", rd, 32'd0);

        // CTRL=0 written on the 1->0 edge wins over INT.
        cyc(1'b0, 1'b0, ADDR_CTRL, 32'h0);
        cyc(1'b1, 1'b1, ADDR_PRESET, 32'd2);
        cyc(1'b1, 1'b1, ADDR_CTRL, 32'h9);
        cyc(1'b1, 1'b0, ADDR_COUNT, 32'h0);
        chk32("race_cnt2", rd, 32'd2);
        cyc(1'b1, 1'b0, ADDR_COUNT, 32'h0);
        chk32("race_cnt1", rd, 32'd1);
        cyc(1'b1, 1'b1, ADDR_CTRL, 32'h0);
        chk32("race_irq_a", {31'd0, irq}, 32'd0);
        chk32("race_ctrl", rd, 32'd0);
        cyc(1'b1, 1'b1, ADDR_CTRL, 32'h8);
        chk32("race_irq_b", {31'd0, irq}, 32'd0);
        cyc(1'b1, 1'b0, ADDR_CTRL, 32'h0);
        chk32("race_irq_c", {31'd0, irq}, 32'd0);

        // IM=0: INT is reached (EN self-clears) but irq stays low.
        cyc(1'b0, 1'b0, ADDR_CTRL, 32'h0);
        cyc(1'b1, 1'b1, ADDR_PRESET, 32'd1);
        cyc(1'b1, 1'b1, ADDR_CTRL, 32'h1);
        cyc(1'b1, 1'b0, ADDR_COUNT, 32'h0);
        chk32("im0_cnt1", rd, 32'd1);
        cyc(1'b1, 1'b0, ADDR_COUNT, 32'h0);
        chk32("im0_cnt0", rd, 32'd0);
        chk32("im0_irq", {31'd0, irq}, 32'd0);
        rdchk("im0_ctrl", ADDR_CTRL, 32'h0);

        // Reset mid-count at COUNT=50, with a write asserted on the reset edge.
        cyc(1'b0, 1'b0, ADDR_CTRL, 32'h0);
        cyc(1'b1, 1'b1, ADDR_PRESET, 32'd100);
        cyc(1'b1, 1'b1, ADDR_CTRL, 32'h1);
        for (int i = 0; i < 51; i++) cyc(1'b1, 1'b0, ADDR_COUNT, 32'h0);
        rdchk("rmid_pre_cnt", ADDR_COUNT, 32'd50);
        cyc(1'b0, 1'b1, ADDR_CTRL, 32'hFFFF_FFFF);
        rdchk("rmid_ctrl", ADDR_CTRL, 32'h0);
        rdchk("rmid_preset", ADDR_PRESET, 32'h0);
        rdchk("rmid_cnt", ADDR_COUNT, 32'h0);
        chk32("rmid_irq", {31'd0, irq}, 32'd0);
        cyc(1'b1, 1'b0, ADDR_COUNT, 32'h0);
        chk32("rmid_idle_cnt", rd, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
